fpu_share_arbiter: RTL
======================

// Module: fpu_share_arbiter
// PURPOSE
//  Shares one FPU/APU port among NB_CORES requesters. Uses round-robin arbitration, holds the choice
//  while the FPU is not ready, caps in-flight operations per core and routes responses by one-hot ID.
//  Sits between the core-side APU ports and the shared FPU in the FPU interconnect.
//  Replaces the stateless arbitration tree wherever fairness and outstanding-op bounds are required.
// PARAMETERS
//  NB_CORES          9   number of requesting cores (any value >=2, not only powers of 2)
//  NB_APU_ARGS       2   operands per request
//  APU_OPCODE_WIDTH  5   opcode width
//  FLAG_WIDTH        6   flag width
//  DATA_WIDTH        32  operand width
//  MAX_OUTSTANDING   2   max in-flight ops per core (>=1); ID_WIDTH = NB_CORES (one-hot)
// PORTS
//  clk              in   1                                 clock
//  rst              in   1                                 async reset, active-high
//  data_req_i       in   NB_CORES                          per-core request
//  data_operands_i  in   NB_CORES*NB_APU_ARGS*DATA_WIDTH   per-core operands
//  data_op_i        in   NB_CORES*APU_OPCODE_WIDTH         per-core opcode
//  data_flag_i      in   NB_CORES*FLAG_WIDTH               per-core flags
//  data_gnt_o       out  NB_CORES                          per-core grant (one-hot or zero)
//  data_req_o       out  1                                 request to FPU
//  data_operands_o  out  NB_APU_ARGS*DATA_WIDTH            muxed operands
//  data_op_o        out  APU_OPCODE_WIDTH                  muxed opcode
//  data_flag_o      out  FLAG_WIDTH                        muxed flags
//  data_ID_o        out  NB_CORES                          one-hot ID of the selected core
//  data_gnt_i       in   1                                 FPU accepts request
//  data_r_valid_i   in   1                                 FPU result valid
//  data_r_ID_i      in   NB_CORES                          one-hot ID of the result
//  data_r_valid_o   out  NB_CORES                          per-core result valid
//  proto_err_o      out  1                                 sticky: response to a core with zero in flight
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0, all cnt[k]=0, proto_err_o=0. With all req_i low, every output is 0.
//  - Eligibility: elig[k] = data_req_i[k] & (cnt[k] < MAX_OUTSTANDING).
//  - IDLE: pick the first eligible k, searching from rr_ptr upward and wrapping past NB_CORES-1.
//    Selection is combinational (0-cycle latency): req_o=1, ID_o=onehot(k), payload muxed from k.
//    data_gnt_o[k] = data_gnt_i.
//  - Handshake: accept = req_o & gnt_i. On accept: cnt[k]++, rr_ptr <= (k+1) mod NB_CORES; stay IDLE.
//  - req_o & !gnt_i -> LOCKED(sel=k). Selection is frozen and cnt/req changes on other cores are ignored.
//    LOCKED drives core sel only, until accept, then returns to IDLE with the same update as IDLE.
//  - LOCKED and data_req_i[sel] drops (violation): req_o=0 that cycle, return to IDLE, no counter change.
//  - Responses: data_r_valid_o = data_r_ID_i & {NB_CORES{data_r_valid_i}}, combinational.
//    On r_valid, cnt[k]-- for the set bit k. If cnt[k]==0: no decrement, proto_err_o<=1 (cleared only by rst).
//  - Same cycle accept and response on one core: cnt unchanged (net 0). cnt never exceeds MAX_OUTSTANDING.
//  - Non-one-hot data_r_ID_i: each set bit is handled independently.
//  - Counter width: $clog2(MAX_OUTSTANDING+1).
//  - Reset mid-operation: counters and lock cleared. In-flight ops lost; later responses flag proto_err_o.
// STRUCTURE
//  - fpu_interco_pkg: arb_state_e {IDLE, LOCKED}; cnt_width() function; onehot-to-index function.
//  - Sub-module fpu_rr_pick: combinational round-robin priority picker.
//    Inputs: elig vector and rr_ptr. Outputs: valid and index.
//  - Top holds the FSM, rr_ptr, counters, payload mux and response routing.
// TESTING (NB_CORES=4, MAX_OUTSTANDING=2)
//  1. Reset, all req low -> req_o=0, gnt_o=0, rr_ptr=0.
//     Assert rst mid-LOCKED -> outputs 0 on the next edge.
//  2. req_i=4'b1111, gnt_i=1 for 4 cycles, responses returned same cycle.
//     -> ID_o sequence 0001,0010,0100,1000, then repeats 0001.
//  3. req_i=4'b0100, gnt_i=0 for 3 cycles, then req_i=4'b0101 with gnt_i=1.
//     -> ID_o held at 0100 throughout; core2 granted first, core0 on the next cycle.
//  4. Core1 alone, gnt_i=1, no responses -> 2 accepts, then req_o=0.
//     One response r_ID=0010 -> core1 re-eligible the next cycle.
//  5. r_valid_i=1, r_ID_i=1000 with cnt[3]=0 -> data_r_valid_o=1000, proto_err_o=1, cnt[3] stays 0.
//  6. Core0 with cnt=1: accept and response on the same cycle -> cnt stays 1.
//     LOCKED core drops req -> req_o=0, FSM back in IDLE.

Source files
------------

// File: rtl/fpu_interco_pkg.sv
// Shared types and helpers for the FPU interconnect arbiter.
// Holds the arbiter FSM state type, counter sizing and one-hot decode.
package fpu_interco_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

    // Index of the highest set bit of a one-hot vector (0 if none).
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: first set elig bit at or after rr_ptr.
// Ports: elig (candidates), rr_ptr (start index) -> valid, idx (winner).
module fpu_rr_pick #(
    parameter int N = 9,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest eligible
    // candidate is the last one written and therefore wins.
    always_comb begin
        logic [IW:0] j;
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = {1'b0, rr_ptr} + (IW + 1)'(i);
            if (j >= (IW + 1)'(N)) j = j - (IW + 1)'(N);
            if (elig[j[IW-1:0]]) begin
                valid = 1'b1;
                idx   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one FPU port among NB_CORES cores, with lock on
// backpressure, per-core in-flight caps and one-hot response routing.
// Ports: core side data_req_i/operands/op/flag -> data_gnt_o, data_r_valid_o;
// FPU side data_req_o/operands/op/flag/ID_o <- data_gnt_i, data_r_valid_i,
// data_r_ID_i; proto_err_o flags a response to a core with nothing in flight.
module fpu_share_arbiter
    import fpu_interco_pkg::*;
#(
    parameter int NB_CORES         = 9,
    parameter int NB_APU_ARGS      = 2,
    parameter int APU_OPCODE_WIDTH = 5,
    parameter int FLAG_WIDTH       = 6,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NB_CORES-1:0]                     data_req_i,
    input  logic [NB_CORES*NB_APU_ARGS*DATA_WIDTH-1:0] data_operands_i,
    input  logic [NB_CORES*APU_OPCODE_WIDTH-1:0]    data_op_i,
    input  logic [NB_CORES*FLAG_WIDTH-1:0]          data_flag_i,
    output logic [NB_CORES-1:0]                     data_gnt_o,
    output logic                                    data_req_o,
    output logic [NB_APU_ARGS*DATA_WIDTH-1:0]       data_operands_o,
    output logic [APU_OPCODE_WIDTH-1:0]             data_op_o,
    output logic [FLAG_WIDTH-1:0]                   data_flag_o,
    output logic [NB_CORES-1:0]                     data_ID_o,
    input  logic                                    data_gnt_i,
    input  logic                                    data_r_valid_i,
    input  logic [NB_CORES-1:0]                     data_r_ID_i,
    output logic [NB_CORES-1:0]                     data_r_valid_o,
    output logic                                    proto_err_o
);

    localparam int IW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam int PW = NB_APU_ARGS * DATA_WIDTH;
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
    localparam logic [IW-1:0] LAST = IW'(NB_CORES - 1);

    arb_state_e          state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       lock_idx;
    logic [CW-1:0]       cnt [NB_CORES];
    logic [NB_CORES-1:0] elig;
    logic [NB_CORES-1:0] zero_v;
    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       sel;
    logic                sel_valid;
    logic [NB_CORES-1:0] sel_oh;
    logic                accept;

    always_comb begin
        elig   = '0;
        zero_v = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            elig[k]   = data_req_i[k] & (cnt[k] < CMAX);
            zero_v[k] = (cnt[k] == '0);
        end
    end

    fpu_rr_pick #(
        .N(NB_CORES)
    ) u_pick (
        .elig  (elig),
        .rr_ptr(rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // While locked, only the held core's request line matters; a dropped
    // request there kills the cycle instead of re-arbitrating.
    always_comb begin
        if (state == LOCKED) begin
            sel       = lock_idx;
            sel_valid = data_req_i[lock_idx];
        end else begin
            sel       = pick_idx;
            sel_valid = pick_valid;
        end
        if (rst) sel_valid = 1'b0;
    end

    assign sel_oh     = sel_valid ? (NB_CORES'(1) << sel) : '0;
    assign accept     = sel_valid & data_gnt_i;
    assign data_req_o = sel_valid;
    assign data_ID_o  = sel_oh;
    assign data_gnt_o = sel_oh & {NB_CORES{data_gnt_i}};

    always_comb begin
        data_operands_o = '0;
        data_op_o       = '0;
        data_flag_o     = '0;
        if (sel_valid) begin
            data_operands_o = data_operands_i[int'(sel)*PW +: PW];
            data_op_o = data_op_i[int'(sel)*APU_OPCODE_WIDTH +: APU_OPCODE_WIDTH];
            data_flag_o = data_flag_i[int'(sel)*FLAG_WIDTH +: FLAG_WIDTH];
        end
    end

    assign data_r_valid_o = data_r_ID_i & {NB_CORES{data_r_valid_i}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_valid && !data_gnt_i) begin
                        state    <= LOCKED;
                        lock_idx <= sel;
                    end
                end
                LOCKED: begin
                    if (!sel_valid || data_gnt_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (accept) rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
        end
    end

    // A response to an idle core is not decremented (it stays at zero)
    // but an accept in the same cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB_CORES; k++) cnt[k] <= '0;
            proto_err_o <= 1'b0;
        end else begin
            for (int k = 0; k < NB_CORES; k++) begin
                if (data_gnt_o[k] && !(data_r_valid_o[k] && !zero_v[k]))
                    cnt[k] <= cnt[k] + 1'b1;
                else if (data_r_valid_o[k] && !data_gnt_o[k] && !zero_v[k])
                    cnt[k] <= cnt[k] - 1'b1;
            end
            if (|(data_r_valid_o & zero_v)) proto_err_o <= 1'b1;
        end
    end

endmodule
